// File: rtl/ama_riscv_trace_tx.sv
// Retire/end trace transmitter: records queued in a small FIFO, then
// serialized as header, W1, W2 words over a valid/ready link.
module ama_riscv_trace_tx #(
    parameter int DEPTH   = 8,
    parameter int DELTA_W = 30   // must be <= 30 so the header fits in 32 bits
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ret_valid,
    input  logic [31:0]              ret_pc,
    input  logic [31:0]              ret_inst,
    input  logic                     tohost_we,
    input  logic [31:0]              tohost_wdata,
    input  logic                     cnt_clr,
    output logic                     tr_valid,
    input  logic                     tr_ready,
    output logic [31:0]              tr_data,
    output logic                     tr_last,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_W1   = 3'd2;
    localparam logic [2:0] S_W2   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [95:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [LW-1:0]      level_q;
    logic [2:0]         state_q;
    logic [95:0]        rec_q;
    logic [95:0]        end_rec_q;
    logic               end_seen_q, pend_q;
    logic [DELTA_W-1:0] delta_q;
    logic               ovf_q;
    logic [15:0]        drop_q;

    logic        full, empty, pop, has_room;
    logic        ret_ev, end_ev, ret_push, end_push, push, drop;
    logic [95:0] ret_rec, end_live, push_data;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign pop      = (state_q == S_IDLE) && !empty;
    assign has_room = !full || pop;

    assign ret_ev = ret_valid && !end_seen_q && (state_q != S_FIN);
    assign end_ev = tohost_we && tohost_wdata[0] && !end_seen_q;

    // A same-cycle retire owns the slot; the end record waits in pend_q.
    assign ret_push = ret_ev && has_room;
    assign drop     = ret_ev && !has_room;
    assign end_push = (pend_q || end_ev) && !ret_ev && has_room;
    assign push     = ret_push || end_push;

    assign ret_rec   = {2'b01, 30'(delta_q), ret_pc, ret_inst};
    assign end_live  = {2'b10, 30'(delta_q), tohost_wdata, 16'h0, drop_q};
    assign push_data = ret_ev ? ret_rec : (pend_q ? end_rec_q : end_live);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (!push && pop) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            end_seen_q <= 1'b0;
            pend_q     <= 1'b0;
            end_rec_q  <= '0;
        end else begin
            if (end_ev) begin
                end_seen_q <= 1'b1;
                end_rec_q  <= end_live;
            end
            if (end_push)    pend_q <= 1'b0;
            else if (end_ev) pend_q <= 1'b1;
        end
    end

    // Dropped retires still count as events for the delta field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delta_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            if (cnt_clr)                delta_q <= '0;
            else if (ret_ev || end_ev)  delta_q <= DELTA_W'(1);
            else if (delta_q != '1)     delta_q <= delta_q + 1'b1;

            if (cnt_clr) begin
                ovf_q  <= 1'b0;
                drop_q <= '0;
            end else if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rec_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (!empty) begin
                    rec_q   <= mem[rd_ptr];
                    state_q <= S_HDR;
                end
                S_HDR:  if (tr_ready) state_q <= S_W1;
                S_W1:   if (tr_ready) state_q <= S_W2;
                S_W2:   if (tr_ready) state_q <= (rec_q[95:94] == 2'b10) ? S_FIN : S_IDLE;
                default: state_q <= state_q;
            endcase
        end
    end

    always_comb begin
        tr_data = '0;
        case (state_q)
            S_HDR:   tr_data = rec_q[95:64];
            S_W1:    tr_data = rec_q[63:32];
            S_W2:    tr_data = rec_q[31:0];
            default: tr_data = '0;
        endcase
    end

    assign tr_valid   = (state_q == S_HDR) || (state_q == S_W1) || (state_q == S_W2);
    assign tr_last    = (state_q == S_W2);
    assign done       = (state_q == S_FIN);
    assign overflow   = ovf_q;
    assign drop_cnt   = drop_q;
    assign fifo_level = level_q;

endmodule
